gp_rect_engine: RTL and testbench

- Graphics-processor side of the gp_* command interface driven by the game controller.
- Accepts one rectangle command: opcode, top-left and bottom-right corners, and a 12-bit colour argument.
- Rasterises the rectangle into VRAM write requests, then signals completion through gp_finish.
- Sits between the game controller and the VRAM write port of the VGA frame buffer.

---
 rtl/gp_rect_engine.sv | 149 ++++++++++++++
 tb/tb_gp_rect_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gp_rect_engine.sv
// rtl/gp_rect_engine.sv - rectangle rasteriser from gp_* command to VRAM write requests
// Optional clipping to the visible screen is enabled by defining GP_CLIP_EN.
module gp_rect_engine #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gp_en,
  input  logic               gp_opcode,
  input  logic [9:0]         gp_tl_x,
  input  logic [8:0]         gp_tl_y,
  input  logic [9:0]         gp_br_x,
  input  logic [8:0]         gp_br_y,
  input  logic [COLOR_W-1:0] gp_arg,
  output logic               gp_finish,
  output logic               vram_we,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [COLOR_W-1:0] vram_data,
  input  logic               vram_ready
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  state_t state, state_next;

  logic               op_q;
  logic [9:0]         tl_x_q, br_x_q, lim_x_q, x_q;
  logic [8:0]         tl_y_q, br_y_q, lim_y_q, y_q;
  logic [COLOR_W-1:0] col_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic               last_q;

  logic [9:0]         bx_clamp;
  logic [8:0]         by_clamp;
  logic               empty;
  logic               stall;
  logic               write_pix;
  logic [ADDR_W-1:0]  row_base_calc;

  always_comb begin
    bx_clamp = br_x_q;
    by_clamp = br_y_q;
`ifdef GP_CLIP_EN
    if (br_x_q > 10'(H_RES - 1)) bx_clamp = 10'(H_RES - 1);
    if (br_y_q > 9'(V_RES - 1))  by_clamp = 9'(V_RES - 1);
    empty = (tl_x_q > 10'(H_RES - 1)) || (tl_y_q > 9'(V_RES - 1)) ||
            (bx_clamp < tl_x_q) || (by_clamp < tl_y_q);
`else
    empty = (tl_x_q > br_x_q) || (tl_y_q > br_y_q);
`endif
    if (H_RES == 640)
      row_base_calc = ADDR_W'({tl_y_q, 9'b0}) + ADDR_W'({tl_y_q, 7'b0});
    else
      row_base_calc = ADDR_W'(32'(tl_y_q) * H_RES);
    stall = vram_we && !vram_ready;
    // Outline edges use the unclamped corner so clipped edges are not drawn.
    write_pix = op_q || (x_q == tl_x_q) || (x_q == br_x_q) ||
                (y_q == tl_y_q) || (y_q == br_y_q);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (gp_en && !gp_finish) state_next = SETUP;
      SETUP: state_next = empty ? DONE : DRAW;
      DRAW:  if (!stall && last_q) state_next = DONE;
      DONE:  if (!gp_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 1'b0;
      tl_x_q     <= '0;
      tl_y_q     <= '0;
      br_x_q     <= '0;
      br_y_q     <= '0;
      lim_x_q    <= '0;
      lim_y_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      last_q     <= 1'b0;
      gp_finish  <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gp_en && !gp_finish) begin
            op_q   <= gp_opcode;
            tl_x_q <= gp_tl_x;
            tl_y_q <= gp_tl_y;
            br_x_q <= gp_br_x;
            br_y_q <= gp_br_y;
            col_q  <= gp_arg;
          end
        end
        SETUP: begin
          x_q        <= tl_x_q;
          y_q        <= tl_y_q;
          lim_x_q    <= bx_clamp;
          lim_y_q    <= by_clamp;
          row_base_q <= row_base_calc;
          last_q     <= 1'b0;
          if (empty) gp_finish <= 1'b1;
        end
        DRAW: begin
          // Each non-stalled cycle retires the presented pixel and presents the next.
          if (!stall) begin
            if (last_q) begin
              vram_we   <= 1'b0;
              gp_finish <= 1'b1;
              last_q    <= 1'b0;
            end else begin
              vram_we   <= write_pix;
              vram_addr <= row_base_q + ADDR_W'(x_q);
              vram_data <= col_q;
              last_q    <= (x_q == lim_x_q) && (y_q == lim_y_q);
              if (x_q < lim_x_q) begin
                x_q <= x_q + 10'd1;
              end else begin
                x_q        <= tl_x_q;
                y_q        <= y_q + 9'd1;
                row_base_q <= row_base_q + ADDR_W'(H_RES);
              end
            end
          end
        end
        DONE: begin
          if (!gp_en) gp_finish <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gp_rect_engine.sv
// tb/tb_gp_rect_engine.sv - scoreboard bench for gp_rect_engine
// Expected pixel stream is generated from a coordinate model at command issue.
module tb_gp_rect_engine;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COLOR_W = 12;
  localparam int ADDR_W  = 19;

  logic               clk = 1'b0;
  logic               rst;
  logic               gp_en;
  logic               gp_opcode;
  logic [9:0]         gp_tl_x, gp_br_x;
  logic [8:0]         gp_tl_y, gp_br_y;
  logic [COLOR_W-1:0] gp_arg;
  logic               gp_finish;
  logic               vram_we;
  logic [ADDR_W-1:0]  vram_addr;
  logic [COLOR_W-1:0] vram_data;
  logic               vram_ready;

  gp_rect_engine #(.H_RES(H_RES), .V_RES(V_RES), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .gp_en(gp_en), .gp_opcode(gp_opcode),
    .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x), .gp_br_y(gp_br_y),
    .gp_arg(gp_arg), .gp_finish(gp_finish), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_data(vram_data), .vram_ready(vram_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int acc_cnt = 0, last_acc_cyc = 0, first_we_cyc = -1;
  int ready_mode = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    vram_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: vram_ready = 1'b1;
        1: vram_ready = ~vram_ready;
        default: vram_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_we", 32'(vram_we), 32'd1);
        check("hold_word", {1'b0, vram_addr, vram_data}, prev_word);
      end
      if (vram_we && first_we_cyc < 0) first_we_cyc = cyc;
      if (vram_we && vram_ready) begin
        if (exp_q.size() == 0) check("extra_write", 32'd0, 32'd1);
        else check("pixel", {1'b0, vram_addr, vram_data}, exp_q.pop_front());
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      prev_stall = vram_we && !vram_ready;
      prev_word  = {1'b0, vram_addr, vram_data};
    end
  end

  task automatic model(input logic op, input int tlx, input int tly, input int brx, input int bry,
                       input logic [COLOR_W-1:0] col, output int writes, output int visited);
    int bx, by;
    logic [ADDR_W-1:0] a;
    bx = brx;
    by = bry;
    writes = 0;
    visited = 0;
`ifdef GP_CLIP_EN
    if (bx > H_RES - 1) bx = H_RES - 1;
    if (by > V_RES - 1) by = V_RES - 1;
`endif
    for (int y = tly; y <= by; y++) begin
      for (int x = tlx; x <= bx; x++) begin
        visited++;
        if (op || x == tlx || x == brx || y == tly || y == bry) begin
          a = ADDR_W'(y * H_RES + x);
          exp_q.push_back({1'b0, a, col});
          writes++;
        end
      end
    end
  endtask

  task automatic issue(input logic op, input int tlx, input int tly, input int brx, input int bry,
                       input logic [COLOR_W-1:0] col);
    @(posedge clk);
    #1;
    gp_opcode    = op;
    gp_tl_x      = 10'(tlx);
    gp_tl_y      = 9'(tly);
    gp_br_x      = 10'(brx);
    gp_br_y      = 9'(bry);
    gp_arg       = col;
    acc_cnt      = 0;
    first_we_cyc = -1;
    gp_en        = 1'b1;
  endtask

  task automatic run_cmd(input logic op, input int tlx, input int tly, input int brx, input int bry,
                         input logic [COLOR_W-1:0] col);
    int writes, visited, raise_cyc, fin_cyc, t;
    model(op, tlx, tly, brx, bry, col, writes, visited);
    issue(op, tlx, tly, brx, bry, col);
    raise_cyc = cyc;
    t = 0;
    @(negedge clk);
    while (!gp_finish && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!gp_finish) begin
      check("finish_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      fin_cyc = cyc;
      check("left_in_queue", 32'(exp_q.size()), 32'd0);
      check("write_count", 32'(acc_cnt), 32'(writes));
      if (writes > 0) begin
        check("finish_after_last", 32'(fin_cyc), 32'(last_acc_cyc + 1));
        check("first_we_latency", 32'(first_we_cyc - raise_cyc), 32'd3);
      end else begin
        check("no_write_seen", 32'(first_we_cyc), 32'hFFFF_FFFF);
      end
      if (ready_mode == 0)
        check("cycles", 32'(fin_cyc - raise_cyc), writes > 0 ? 32'(visited + 3) : 32'd2);
    end
    gp_en = 1'b0;
    @(negedge clk);
    check("finish_fall", 32'(gp_finish), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int writes, visited, t;
    rst = 1'b1;
    gp_en = 1'b0;
    gp_opcode = 1'b0;
    gp_tl_x = '0;
    gp_tl_y = '0;
    gp_br_x = '0;
    gp_br_y = '0;
    gp_arg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_finish", 32'(gp_finish), 32'd0);
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_addr", 32'(vram_addr), 32'd0);
    check("rst_data", 32'(vram_data), 32'd0);
    rst = 1'b0;

    ready_mode = 0;
    run_cmd(1'b1, 10, 5, 11, 6, 12'hABC);
    run_cmd(1'b0, 2, 2, 4, 4, 12'hF00);
    ready_mode = 1;
    run_cmd(1'b1, 0, 0, 3, 0, 12'h123);
    ready_mode = 0;
    run_cmd(1'b1, 5, 5, 4, 5, 12'h555);
    run_cmd(1'b1, 0, 470, 639, 479, 12'h000);
    run_cmd(1'b0, 7, 3, 7, 3, 12'h0F0);
    ready_mode = 2;
    run_cmd(1'b0, 1, 1, 6, 1, 12'h00F);
    run_cmd(1'b0, 2, 0, 2, 4, 12'h321);
    run_cmd(1'b0, 20, 10, 25, 14, 12'h777);
    run_cmd(1'b1, 0, 0, 4, 3, 12'hFFF);

    ready_mode = 0;
    model(1'b1, 0, 0, 99, 99, 12'h3C3, writes, visited);
    issue(1'b1, 0, 0, 99, 99, 12'h3C3);
    t = 0;
    @(negedge clk);
    while (acc_cnt < 50 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("reached_50_writes", 32'(acc_cnt >= 50), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_we", 32'(vram_we), 32'd0);
    check("abort_finish", 32'(gp_finish), 32'd0);
    gp_en = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("abort_we_held", 32'(vram_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(1'b1, 3, 3, 5, 4, 12'h9A5);

`ifdef GP_CLIP_EN
    run_cmd(1'b1, 638, 478, 700, 500, 12'hE1E);
    run_cmd(1'b1, 640, 0, 700, 5, 12'h111);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
